// File: rtl/sc_spawn_scheduler.sv
// sc_spawn_scheduler: turns the random bus into timed obstacle-spawn offers.
// Draws a tick interval, then a lane/column, and offers them over valid/ready.
// Optional feature macro: SPAWN_TIMEOUT_EN drops an offer left unaccepted for
// TIMEOUT_TICKS ticks and counts the drops in drop_count.
module sc_spawn_scheduler #(
   parameter int unsigned MIN_GAP       = 8,
   parameter int unsigned TIMEOUT_TICKS = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       tick,
   input  logic [7:0] rnd,
   input  logic       spawn_ready,
   output logic       spawn_valid,
   output logic [1:0] spawn_lane,
   output logic [2:0] spawn_col,
   output logic [7:0] drop_count
);

   // Interval counter must hold MIN_GAP + 15; never narrower than 5 bits.
   localparam int unsigned cnt_raw = $clog2(MIN_GAP + 16);
   localparam int unsigned cnt_w   = (cnt_raw > 5) ? cnt_raw : 5;

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StOffer} state_e;

   state_e           state_q, state_d;
   logic [cnt_w-1:0] cnt_q;
   logic [1:0]       lane_q;
   logic [2:0]       col_q;
   logic [1:0]       last_lane_q;
   logic             last_valid_q;

   logic             accept;
   logic             wait_done;
   logic             drop;
   logic [7:0]       drop_val;
   logic [1:0]       raw_lane;
   logic [1:0]       cand_lane;

   // rnd[7] and rnd[0] are always zero on the bus.
   logic unused_rnd;
   assign unused_rnd = rnd[7] ^ rnd[0];

   assign accept    = (state_q == StOffer) && spawn_ready;
   assign wait_done = (state_q == StWait) && enable && tick && (cnt_q == cnt_w'(1));
   assign raw_lane  = rnd[2:1];
   // Bump to the next lane when the draw repeats the last accepted lane.
   assign cand_lane = (last_valid_q && (raw_lane == last_lane_q)) ? raw_lane + 2'd1 : raw_lane;

`ifdef SPAWN_TIMEOUT_EN
   localparam int unsigned tmo_raw = $clog2(TIMEOUT_TICKS + 1);
   localparam int unsigned tmo_w   = (tmo_raw > 1) ? tmo_raw : 1;

   logic [tmo_w-1:0] tmo_q;
   logic [7:0]       drop_q;
   logic             tmo_step;

   // An accept in the same cycle as a tick wins; the tick is not counted.
   assign tmo_step = (state_q == StOffer) && enable && tick && !spawn_ready;
   assign drop     = tmo_step && (tmo_q == tmo_w'(TIMEOUT_TICKS - 1));
   assign drop_val = drop_q;

   // Timeout counter and saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q  <= '0;
         drop_q <= '0;
      end else if (!enable || wait_done) begin
         tmo_q <= '0;
      end else if (tmo_step) begin
         tmo_q <= drop ? '0 : tmo_q + tmo_w'(1);
         if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_TICKS == 0);
   assign drop       = 1'b0;
   assign drop_val   = 8'd0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; enable low returns to idle from anywhere.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:  state_d = StLoad;
            StLoad:  state_d = StWait;
            StWait:  if (wait_done) state_d = StOffer;
            StOffer: if (accept || drop) state_d = StLoad;
            default: state_d = StIdle;
         endcase
      end
   end

   // Interval counter, offer payload capture and last-accepted-lane memory.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q        <= '0;
         lane_q       <= '0;
         col_q        <= '0;
         last_lane_q  <= '0;
         last_valid_q <= 1'b0;
      end else begin
         if (!enable) begin
            cnt_q <= '0;
         end else if (state_q == StLoad) begin
            cnt_q <= cnt_w'(MIN_GAP) + cnt_w'(rnd[6:3]);
         end else if ((state_q == StWait) && tick) begin
            cnt_q <= cnt_q - cnt_w'(1);
         end
         if (wait_done) begin
            lane_q <= cand_lane;
            col_q  <= rnd[6:4];
         end
         if (accept) begin
            last_lane_q  <= lane_q;
            last_valid_q <= 1'b1;
         end
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      spawn_valid = (state_q == StOffer);
      spawn_lane  = lane_q;
      spawn_col   = col_q;
      drop_count  = drop_val;
   end

endmodule

// File: tb/tb_sc_spawn_scheduler.sv
// Self-checking bench for sc_spawn_scheduler; build with or without
// SPAWN_TIMEOUT_EN, matching the RTL build.
module tb_sc_spawn_scheduler;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       tick;
   logic [7:0] rnd;
   logic       spawn_ready;
   logic       spawn_valid;
   logic [1:0] spawn_lane;
   logic [2:0] spawn_col;
   logic [7:0] drop_count;

   int checks = 0;
   int errors = 0;

   // Expected {lane, col} of each offer, in order.
   logic [4:0] sb[$];

`ifdef SPAWN_TIMEOUT_EN
   localparam int DropExp = 1;
`else
   localparam int DropExp = 0;
`endif

   sc_spawn_scheduler #(
      .MIN_GAP       (8),
      .TIMEOUT_TICKS (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .tick        (tick),
      .rnd         (rnd),
      .spawn_ready (spawn_ready),
      .spawn_valid (spawn_valid),
      .spawn_lane  (spawn_lane),
      .spawn_col   (spawn_col),
      .drop_count  (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   // N ticks with idle gaps; valid must stay low until the Nth tick is seen.
   task automatic give_ticks(input int n, input logic [7:0] r);
      for (int i = 1; i <= n; i++) begin
         rnd  = r;
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         if (i < n) begin
            check("early_valid", {31'd0, spawn_valid}, 32'd0);
            cyc();
         end
      end
      check("valid_rise", {31'd0, spawn_valid}, 32'd1);
   endtask

   // Monitor: every rising spawn_valid consumes one scoreboard entry.
   initial begin
      logic       prev;
      logic [4:0] exp;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (spawn_valid && !prev) begin
            if (sb.size() == 0) begin
               check("unexpected_offer", {27'd0, spawn_lane, spawn_col}, 32'hFFFF_FFFF);
            end else begin
               exp = sb.pop_front();
               check("offer_payload", {27'd0, spawn_lane, spawn_col}, {27'd0, exp});
            end
         end
         prev = spawn_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      tick        = 1'b0;
      rnd         = 8'h00;
      spawn_ready = 1'b0;
      cyc(); cyc(); cyc();
      reset = 1'b0;
      cyc();
      check("rst_valid", {31'd0, spawn_valid}, 32'd0);
      check("rst_lane",  {30'd0, spawn_lane},  32'd0);
      check("rst_col",   {29'd0, spawn_col},   32'd0);
      check("rst_drop",  {24'd0, drop_count},  32'd0);

      // First spawn: interval 8+5=13, lane 1, col 2; tick in LOAD ignored.
      enable = 1'b1;
      cyc();
      rnd  = 8'h2A;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      check("load_valid", {31'd0, spawn_valid}, 32'd0);
      sb.push_back({2'd1, 3'd2});
      give_ticks(13, 8'h2A);

      // Accept; then a repeat of lane 1 bumps to lane 2.
      spawn_ready = 1'b1;
      cyc();
      spawn_ready = 1'b0;
      check("accept_fall", {31'd0, spawn_valid}, 32'd0);
      rnd = 8'h00;
      cyc();
      sb.push_back({2'd2, 3'd0});
      give_ticks(8, 8'h02);

      // Unaccepted offer under ticks.
`ifdef SPAWN_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         if (i < 4) begin
            check("offer_hold", {31'd0, spawn_valid}, 32'd1);
            cyc();
         end
      end
      check("drop_valid", {31'd0, spawn_valid}, 32'd0);
      check("drop_count", {24'd0, drop_count},  32'd1);
`else
      for (int i = 1; i <= 10; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         check("hold_valid", {31'd0, spawn_valid}, 32'd1);
         check("hold_lane",  {30'd0, spawn_lane},  32'd2);
         check("hold_col",   {29'd0, spawn_col},   32'd0);
         cyc();
      end
`endif
      enable = 1'b0;
      cyc();
      check("disable_valid", {31'd0, spawn_valid}, 32'd0);
      check("disable_drop",  {24'd0, drop_count},  DropExp);

      // Deassert enable mid-WAIT, then the full 8-tick interval restarts.
      enable = 1'b1;
      cyc();
      rnd = 8'h00;
      cyc();
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         cyc();
      end
      enable = 1'b0;
      cyc();
      check("midwait_valid", {31'd0, spawn_valid}, 32'd0);
      enable = 1'b1;
      cyc();
      rnd = 8'h00;
      cyc();
      sb.push_back({2'd2, 3'd7});
      give_ticks(8, 8'h7C);

      // Accept coinciding with the 4th offer tick wins over the timeout.
      for (int i = 1; i <= 4; i++) begin
         tick        = 1'b1;
         spawn_ready = (i == 4);
         cyc();
         tick        = 1'b0;
         spawn_ready = 1'b0;
         if (i < 4) begin
            check("tick_hold", {31'd0, spawn_valid}, 32'd1);
            cyc();
         end
      end
      check("tick_accept_valid", {31'd0, spawn_valid}, 32'd0);
      check("tick_accept_drop",  {24'd0, drop_count},  DropExp);
      rnd = 8'h00;
      cyc();
      sb.push_back({2'd3, 3'd0});
      give_ticks(8, 8'h04);

      // Withdraw an open offer via enable.
      enable = 1'b0;
      cyc();
      check("withdraw_valid", {31'd0, spawn_valid}, 32'd0);
      enable = 1'b1;
      cyc();
      rnd = 8'h00;
      cyc();
      sb.push_back({2'd3, 3'd0});
      give_ticks(8, 8'h06);

      // Reset during OFFER with ready high: nothing is recorded.
      reset       = 1'b1;
      spawn_ready = 1'b1;
      cyc();
      check("rst_offer_valid", {31'd0, spawn_valid}, 32'd0);
      check("rst_offer_lane",  {30'd0, spawn_lane},  32'd0);
      check("rst_offer_col",   {29'd0, spawn_col},   32'd0);
      check("rst_offer_drop",  {24'd0, drop_count},  32'd0);
      reset       = 1'b0;
      spawn_ready = 1'b0;
      cyc();
      rnd = 8'h00;
      cyc();
      sb.push_back({2'd0, 3'd0});
      give_ticks(8, 8'h00);
      spawn_ready = 1'b1;
      cyc();
      spawn_ready = 1'b0;
      check("final_accept", {31'd0, spawn_valid}, 32'd0);
      cyc(); cyc();
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
